rot_programmer: RTL and testbench

Configuration front end that drives the `trig` inputs of a row of rotatable logic cells. It accepts a stream of 2-bit target rotations, one per cell, and keeps a shadow copy of each cell's current rotation. It then issues exactly the number of `trig` pulses each cell needs to reach its target, modulo 4. It sits directly upstream of the logic-cell array and shares its clock and reset.

---
 rtl/rotfpga_pkg.sv | 9 +
 rtl/rot_programmer_if.sv | 12 +
 rtl/rot_shadow_slot.sv | 42 ++++
 rtl/rot_programmer.sv | 105 ++++++++++
 tb/tb_rot_programmer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rotfpga_pkg.sv
// Shared types and constants for the rotatable-cell programmer.
package rotfpga_pkg;

    localparam int unsigned ROT_W        = 2;
    localparam int unsigned APPLY_PHASES = 3;

    typedef enum logic [1:0] {IDLE, LOAD, APPLY, DONE} prog_state_t;

endpackage

// File: rtl/rot_programmer_if.sv
// Valid/ready target-rotation stream into the programmer.
interface rot_programmer_if;
    import rotfpga_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [ROT_W-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);

endinterface

// File: rtl/rot_shadow_slot.sv
// Per-cell target/shadow pair; emits trig while the wrapped delta exceeds the phase.
module rot_shadow_slot
    import rotfpga_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ROT_W-1:0] wr_data,
    input  logic             issue,
    input  logic [ROT_W-1:0] phase,
    input  logic             commit,
    output logic             trig
);

    logic [ROT_W-1:0] target_q;
    logic [ROT_W-1:0] shadow_q;
    logic [ROT_W-1:0] target_eff;
    logic [ROT_W-1:0] delta;
    logic             trig_q;

    // Bypass lets phase 0 issue on the same edge that writes the last target.
    assign target_eff = wr_en ? wr_data : target_q;
    assign delta      = target_eff - shadow_q;
    assign trig       = trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            shadow_q <= '0;
            trig_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                target_q <= wr_data;
            end
            if (commit) begin
                shadow_q <= target_q;
            end
            trig_q <= issue && (delta > phase);
        end
    end

endmodule

// File: rtl/rot_programmer.sv
// Loads one target rotation per cell, then pulses trig (target - shadow) mod 4 times per cell.
module rot_programmer
    import rotfpga_pkg::*;
#(
    parameter int unsigned N_CELLS = 16,
    parameter int unsigned IDX_W   = $clog2(N_CELLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    rot_programmer_if.slave    cfg,
    output logic [N_CELLS-1:0] trig,
    output logic               busy,
    output logic               done
);

    localparam int unsigned    IW         = (IDX_W > 0) ? IDX_W : 1;
    localparam logic [IW-1:0]  LAST_IDX   = IW'(N_CELLS - 1);
    localparam logic [ROT_W-1:0] LAST_PHASE = ROT_W'(APPLY_PHASES - 1);

    prog_state_t      state_q;
    logic [IW-1:0]    idx_q;
    logic [ROT_W-1:0] phase_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             last_beat;
    logic             in_apply;
    logic             last_phase;
    logic             issue;
    logic             commit;
    logic [ROT_W-1:0] cmp_phase;

    // idx_q is 0 in IDLE, so a single-cell build finishes on the first beat.
    assign accept     = cfg.cfg_valid & ready_q;
    assign last_beat  = accept && (idx_q == LAST_IDX);
    assign in_apply   = (state_q == APPLY);
    assign last_phase = (phase_q == LAST_PHASE);
    assign issue      = last_beat | (in_apply & ~last_phase);
    assign commit     = in_apply & last_phase;
    assign cmp_phase  = last_beat ? '0 : phase_q + 1'b1;

    assign cfg.cfg_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;

    for (genvar i = 0; i < N_CELLS; i++) begin : g_slot
        rot_shadow_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (accept && (idx_q == IW'(i))),
            .wr_data (cfg.cfg_data),
            .issue   (issue),
            .phase   (cmp_phase),
            .commit  (commit),
            .trig    (trig[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            phase_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, LOAD: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (last_beat) begin
                            state_q <= APPLY;
                            idx_q   <= '0;
                            phase_q <= '0;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                APPLY: begin
                    if (last_phase) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_programmer.sv
// Table-driven and randomized checks of rot_programmer against a delta-count model.
module tb_rot_programmer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] trig;
    logic        busy;
    logic        done;
    logic [0:0]  trig1;
    logic        busy1;
    logic        done1;

    rot_programmer_if cfg_if ();
    rot_programmer_if n1_if ();

    rot_programmer #(.N_CELLS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg   (cfg_if),
        .trig  (trig),
        .busy  (busy),
        .done  (done)
    );

    rot_programmer #(.N_CELLS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg   (n1_if),
        .trig  (trig1),
        .busy  (busy1),
        .done  (done1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  gapmode;
        logic [31:0] tgt;
        logic [31:0] expp;
    } vec_t;

    vec_t vecs [4];
    int   shadow_m [16];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cfg_if.cfg_ready === 1'b1) seen = 1;
        end
        chk("ready_timeout", 32'(seen), 32'd1);
    endtask

    // gapmode: 0 back-to-back, 1 one idle cycle between beats, 2 random 0..2 idle cycles
    task automatic load_beats(input logic [31:0] tgt, input logic [1:0] gapmode);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                wait_ready();
            end else begin
                int ngap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
                for (int g = 0; g < ngap; g++) begin
                    @(negedge clk);
                    cfg_if.cfg_data = 2'($urandom);
                    chk("ready_in_gap", 32'(cfg_if.cfg_ready), 32'd1);
                    chk("trig_in_gap", 32'(trig), 32'd0);
                    chk("busy_in_gap", 32'(busy), 32'd1);
                end
                @(negedge clk);
                chk("ready_beat", 32'(cfg_if.cfg_ready), 32'd1);
            end
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = tgt[2*i +: 2];
            @(posedge clk);
            #1 cfg_if.cfg_valid = 1'b0;
        end
    endtask

    task automatic check_apply(input logic [31:0] expp);
        logic [31:0] cnt = '0;
        logic [15:0] et;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                et[i] = (k < 3) && (k < int'(expp[2*i +: 2]));
                if (trig[i] === 1'b1) cnt[2*i +: 2] = cnt[2*i +: 2] + 2'd1;
            end
            chk($sformatf("trig_k%0d", k), 32'(trig), 32'(et));
            chk($sformatf("done_k%0d", k), 32'(done), 32'(k == 3));
            chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k < 4));
            chk($sformatf("ready_k%0d", k), 32'(cfg_if.cfg_ready), 32'(k >= 4));
        end
        chk("pulse_counts", cnt, expp);
    endtask

    function automatic logic [31:0] model_run(input logic [31:0] tgt);
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            e[2*i +: 2] = 2'((int'(tgt[2*i +: 2]) - shadow_m[i] + 4) % 4);
            shadow_m[i] = int'(tgt[2*i +: 2]);
        end
        return e;
    endfunction

    initial begin
        logic [31:0] t;
        logic [31:0] e;
        int          pat4 [4];

        for (int i = 0; i < 16; i++) begin
            vecs[0].tgt[2*i +: 2] = 2'd2;
            vecs[0].expp[2*i +: 2] = 2'd2;
            vecs[1].tgt[2*i +: 2] = 2'(i % 4);
            pat4 = '{2, 3, 0, 1};
            vecs[1].expp[2*i +: 2] = 2'(pat4[i % 4]);
            vecs[2].tgt[2*i +: 2] = 2'(i % 4);
            vecs[2].expp[2*i +: 2] = 2'd0;
            vecs[3].tgt[2*i +: 2] = 2'(3 - i % 4);
            pat4 = '{3, 1, 3, 1};
            vecs[3].expp[2*i +: 2] = 2'(pat4[i % 4]);
            shadow_m[i] = 0;
        end
        vecs[0].gapmode = 2'd0;
        vecs[1].gapmode = 2'd0;
        vecs[2].gapmode = 2'd0;
        vecs[3].gapmode = 2'd1;

        rst_n = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 2'd0;
        n1_if.cfg_valid  = 1'b0;
        n1_if.cfg_data   = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("rst_trig1", 32'(trig1), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load_beats(vecs[v].tgt, vecs[v].gapmode);
            check_apply(vecs[v].expp);
            void'(model_run(vecs[v].tgt));
        end

        // Reset during phase 1 of an all-3 run
        t = '1;
        load_beats(t, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_trig", 32'(trig), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 16; i++) shadow_m[i] = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 32'h5555_5555;
        e = model_run(t);
        chk("model_all1", e, 32'h5555_5555);
        load_beats(t, 2'd0);
        check_apply(e);

        for (int r = 0; r < 4; r++) begin
            t = $urandom;
            e = model_run(t);
            load_beats(t, 2'd2);
            check_apply(e);
        end

        // Single-cell build: first beat goes straight to APPLY
        begin
            bit seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (n1_if.cfg_ready === 1'b1) seen = 1;
            end
            chk("n1_ready_timeout", 32'(seen), 32'd1);
        end
        n1_if.cfg_valid = 1'b1;
        n1_if.cfg_data  = 2'd3;
        @(posedge clk);
        #1 n1_if.cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("n1_trig_k%0d", k), 32'(trig1), 32'(k < 3));
            chk($sformatf("n1_done_k%0d", k), 32'(done1), 32'(k == 3));
            chk($sformatf("n1_busy_k%0d", k), 32'(busy1), 32'(k < 4));
            chk($sformatf("n1_ready_k%0d", k), 32'(n1_if.cfg_ready), 32'(k >= 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
